// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access controller.
//   - SZ_BYTE / SZ_HALF / SZ_WORD : cpu_size encodings (2'b11 is illegal)
//   - state_t                     : controller FSM states
//   - align_ok()                  : natural-alignment test for a size/address pair
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Only the two low address bits matter for alignment. The illegal size
    // encoding is reported as misaligned so one test covers both error cases.
    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: align_ok = 1'b1;
            SZ_HALF: align_ok = ~addr_lo[0];
            SZ_WORD: align_ok = (addr_lo == 2'b00);
            default: align_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane logic for dmem_ctrl.
// Ports:
//   ld_word  in  32 : word read from RAM
//   addr_lo  in   2 : byte offset within the word
//   size     in   2 : access size (SZ_*)
//   sign     in   1 : 1 = sign-extend sub-word loads
//   ld_data  out 32 : extracted and extended load result
//   st_old   in  32 : current RAM word (read half of a read-modify-write)
//   st_wdata in  32 : right-aligned store data
//   st_word  out 32 : st_old with the addressed lane replaced by st_wdata
// Inputs are assumed aligned; misaligned accesses never reach this block.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_word
);

    // Bit offset of the addressed lane; 0 or 16 for halves, 0 for words.
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign sh = {addr_lo, 3'b000};

    always_comb begin
        shifted = ld_word >> sh;
        ld_data = '0;
        case (size)
            SZ_BYTE: ld_data = {{24{sign & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = {{16{sign & shifted[15]}}, shifted[15:0]};
            SZ_WORD: ld_data = ld_word;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF << sh;
            SZ_HALF: mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        st_word = (st_old & ~mask) | ((st_wdata << sh) & mask);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: CPU-side controller for a slow, word-addressed data RAM.
// Handles byte/half/word loads (sign/zero extension), sub-word stores via
// read-modify-write, misalignment errors and a per-phase stall timeout.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   cpu_req/we/size/sign    : request and its attributes (held until cpu_done)
//   cpu_addr, cpu_wdata     : byte address, right-aligned store data
//   cpu_rdata/done/err      : registered result, one-cycle done pulse, error flag
//   cpu_stall               : cpu_req & ~cpu_done (combinational)
//   ram_cs/we/addr/din      : registered RAM controls, stable for a whole phase
//   ram_dout, ram_stall     : RAM read data and busy indication
//   dbg_state               : current FSM state (state_t encoding)
//
// Handshake: a request is taken when cpu_req=1 in IDLE while cpu_done=0; the
// CPU then holds every cpu_* field until the single-cycle cpu_done pulse, during
// which cpu_rdata/cpu_err are valid. On the RAM side, a phase starts when ram_cs
// rises or ram_we changes and ends on the first rising edge with ram_stall=0.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_stall,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic        ram_stall,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] tcnt_nxt;
    logic [31:0]      word_q;
    logic             err_q;
    // Request attributes captured at accept, so the access finishes coherently
    // even if the CPU drops cpu_req early.
    logic             op_we;
    logic [1:0]       op_size;
    logic             op_sign;
    logic [1:0]       op_lo;
    logic [31:0]      ld_data;
    logic [31:0]      st_word;

    assign tcnt_nxt  = tcnt + CNT_W'(1);
    assign cpu_stall = cpu_req & ~cpu_done;
    assign dbg_state = state;

    // Extraction works from the captured word; the merge works from ram_dout
    // because the merged word must be loaded into ram_din on the capture edge.
    // ram_din holds the right-aligned store data throughout the read phase.
    dmem_lane u_lane (
        .ld_word  (word_q),
        .addr_lo  (op_lo),
        .size     (op_size),
        .sign     (op_sign),
        .ld_data  (ld_data),
        .st_old   (ram_dout),
        .st_wdata (ram_din),
        .st_word  (st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
            op_we     <= 1'b0;
            op_size   <= 2'b00;
            op_sign   <= 1'b0;
            op_lo     <= 2'b00;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    // cpu_done=1 here means the previous access is still being
                    // reported; its request must not be taken a second time.
                    if (cpu_req && !cpu_done) begin
                        tcnt    <= '0;
                        err_q   <= 1'b0;
                        op_we   <= cpu_we;
                        op_size <= cpu_size;
                        op_sign <= cpu_sign;
                        op_lo   <= cpu_addr[1:0];
                        if (!align_ok(cpu_size, cpu_addr[1:0])) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            ram_cs   <= 1'b1;
                            ram_addr <= {2'b00, cpu_addr[31:2]};
                            ram_din  <= cpu_wdata;
                            if (cpu_we && cpu_size == SZ_WORD) begin
                                ram_we <= 1'b1;
                                state  <= ST_WR;
                            end else begin
                                ram_we <= 1'b0;
                                state  <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (!ram_stall) begin
                        word_q <= ram_dout;
                        tcnt   <= '0;
                        if (op_we) begin
                            // Same address, cs kept high: only we and din change.
                            ram_we  <= 1'b1;
                            ram_din <= st_word;
                            state   <= ST_WR;
                        end else begin
                            ram_cs <= 1'b0;
                            state  <= ST_DONE;
                        end
                    end else if (tcnt_nxt == CNT_LAST) begin
                        tcnt   <= tcnt_nxt;
                        ram_cs <= 1'b0;
                        err_q  <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end
                ST_WR: begin
                    if (!ram_stall) begin
                        ram_cs <= 1'b0;
                        ram_we <= 1'b0;
                        state  <= ST_DONE;
                    end else if (tcnt_nxt == CNT_LAST) begin
                        tcnt   <= tcnt_nxt;
                        ram_cs <= 1'b0;
                        ram_we <= 1'b0;
                        err_q  <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end
                ST_DONE: begin
                    cpu_done  <= 1'b1;
                    cpu_err   <= err_q;
                    cpu_rdata <= (err_q || op_we) ? 32'h0 : ld_data;
                    tcnt      <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl with a stalling RAM model.
// Each request pushes its expected response (data, error, latency, RAM address,
// written word) into exp_q; a negedge monitor pops and compares at cpu_done.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic        cpu_req, cpu_we, cpu_sign;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_err, cpu_stall;
    logic        ram_cs, ram_we, ram_stall;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic [1:0]  dbg_state;

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_size  (cpu_size),
        .cpu_sign  (cpu_sign),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_stall (cpu_stall),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_stall (ram_stall),
        .dbg_state (dbg_state)
    );

    // ---------------- RAM model ----------------
    // Stall lasts stall_n cycles from the start of each phase; a phase restarts
    // when cs rises or addr/we change.
    logic [31:0] mem [0:63];
    int          stall_n;
    int          age_q;
    logic        last_cs, last_we;
    logic [31:0] last_addr;
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;
    logic        same_ph;

    assign same_ph   = ram_cs && last_cs && (ram_addr == last_addr) && (ram_we == last_we);
    assign ram_stall = ram_cs && ((same_ph ? age_q : 0) < stall_n);
    assign ram_dout  = mem[ram_addr[5:0]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (ram_cs && ram_we && !ram_stall) mem[ram_addr[5:0]] <= ram_din;
        age_q     <= same_ph ? age_q + 1 : 1;
        last_cs   <= ram_cs;
        last_we   <= ram_we;
        last_addr <= ram_addr;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        cs_used;
        logic [7:0]  lat;
        logic        chk_din;
        logic [31:0] din;
        logic [31:0] raddr;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);
    logic [EXP_W-1:0] exp_q[$];

    // Direct checks posted by the stimulus thread, evaluated by the monitor.
    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;
    dchk_t dchk_q[$];

    int errors = 0;
    int checks = 0;

    task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dchk_q.push_back(d);
    endtask

    // ---------------- monitor ----------------
    int          lat_cnt;
    logic        saw_cs, saw_we, moved, prev_done;
    logic [31:0] first_addr, wr_din;

    always @(negedge clk) begin
        exp_t  e;
        dchk_t d;
        if (!rst_n) begin
            lat_cnt = 0; saw_cs = 0; saw_we = 0; moved = 0; prev_done = 0;
            first_addr = '0; wr_din = '0;
        end else begin
            if (prev_done) do_check("done_one_cycle", {31'b0, cpu_done}, 32'h0);
            prev_done = cpu_done;
            if (cpu_stall) lat_cnt++;
            if (ram_cs) begin
                if (!saw_cs) first_addr = ram_addr;
                else if (ram_addr != first_addr) moved = 1;
                if (ram_we) begin
                    if (saw_we && ram_din != wr_din) moved = 1;
                    wr_din = ram_din;
                    saw_we = 1;
                end
                saw_cs = 1;
            end
            if (cpu_done) begin
                if (exp_q.size() == 0) begin
                    do_check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    do_check("rdata", cpu_rdata, e.rdata);
                    do_check("err", {31'b0, cpu_err}, {31'b0, e.err});
                    do_check("latency", 32'(lat_cnt), {24'b0, e.lat});
                    do_check("ram_cs_used", {31'b0, saw_cs}, {31'b0, e.cs_used});
                    if (e.cs_used) begin
                        do_check("ram_addr", first_addr, e.raddr);
                        do_check("ram_stable", {31'b0, moved}, 32'h0);
                    end
                    if (e.chk_din) do_check("ram_din", wr_din, e.din);
                end
                lat_cnt = 0; saw_cs = 0; saw_we = 0; moved = 0;
            end
        end
        while (dchk_q.size() > 0) begin
            d = dchk_q.pop_front();
            do_check(d.name, d.act, d.exp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pl_idx = idx; pl_data = data; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err, input logic cs_used,
                              input int lat, input logic chk_din, input logic [31:0] din,
                              input logic [31:0] raddr);
        exp_t e;
        e.rdata = rdata; e.err = err; e.cs_used = cs_used; e.lat = 8'(lat);
        e.chk_din = chk_din; e.din = din; e.raddr = raddr;
        exp_q.push_back(e);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_sign = sign;
        cpu_addr = addr; cpu_wdata = wdata;
        for (int n = 0; n < 300 && !got; n++) begin
            @(posedge clk); #1;
            if (cpu_done) got = 1'b1;
        end
        post("done_wait", {31'b0, got}, 32'h1);
        cpu_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    // Latency = negedge samples with cpu_stall=1: one before the accept edge,
    // then N+2 for a load/word store (N = RAM stall cycles), 2N+3 for a
    // sub-word store, 1 for an error with no RAM access, TIMEOUT+1 on timeout.
    initial begin
        rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_sign = 0;
        cpu_addr = 0; cpu_wdata = 0; stall_n = 0; pl_en = 0; pl_idx = 0; pl_data = 0;

        preload(6'd4, 32'hDEAD_BEEF);
        preload(6'd2, 32'h1122_3344);
        preload(6'd12, 32'hCAFE_F00D);
        post("rst_ctrl", {26'b0, ram_cs, ram_we, cpu_done, cpu_err, dbg_state}, 32'h0);
        post("rst_data", ram_addr | ram_din | cpu_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Word load, 8-cycle RAM stall.
        stall_n = 8;
        expect_rsp(32'hDEAD_BEEF, 0, 1, 11, 0, 0, 32'h4);
        do_req(0, SZ_WORD, 0, 32'h10, 0);

        // Sub-word loads from 0x80FF7F01.
        preload(6'd4, 32'h80FF_7F01);
        stall_n = 0;
        expect_rsp(32'hFFFF_FF80, 0, 1, 3, 0, 0, 32'h4);
        do_req(0, SZ_BYTE, 1, 32'h13, 0);
        stall_n = 1;
        expect_rsp(32'h0000_00FF, 0, 1, 4, 0, 0, 32'h4);
        do_req(0, SZ_BYTE, 0, 32'h12, 0);
        expect_rsp(32'hFFFF_80FF, 0, 1, 4, 0, 0, 32'h4);
        do_req(0, SZ_HALF, 1, 32'h12, 0);
        expect_rsp(32'h0000_007F, 0, 1, 4, 0, 0, 32'h4);
        do_req(0, SZ_BYTE, 1, 32'h11, 0);

        // Sub-word stores via read-modify-write.
        stall_n = 2;
        expect_rsp(32'h0, 0, 1, 8, 1, 32'hABCD_3344, 32'h2);
        do_req(1, SZ_HALF, 0, 32'h0A, 32'h0000_ABCD);
        post("mem_half_store", mem[2], 32'hABCD_3344);
        expect_rsp(32'h0, 0, 1, 8, 1, 32'hABCD_5A44, 32'h2);
        do_req(1, SZ_BYTE, 0, 32'h09, 32'hFFFF_FF5A);
        expect_rsp(32'hABCD_5A44, 0, 1, 5, 0, 0, 32'h2);
        do_req(0, SZ_WORD, 0, 32'h08, 0);

        // Word store then read back.
        stall_n = 3;
        expect_rsp(32'h0, 0, 1, 6, 1, 32'h1234_5678, 32'h8);
        do_req(1, SZ_WORD, 0, 32'h20, 32'h1234_5678);
        post("mem_word_store", mem[8], 32'h1234_5678);

        // Misaligned / illegal size: error, no RAM access.
        expect_rsp(32'h0, 1, 0, 2, 0, 0, 32'h0);
        do_req(0, SZ_WORD, 0, 32'h06, 0);
        expect_rsp(32'h0, 1, 0, 2, 0, 0, 32'h0);
        do_req(1, SZ_HALF, 0, 32'h05, 32'hFFFF);
        expect_rsp(32'h0, 1, 0, 2, 0, 0, 32'h0);
        do_req(0, 2'b11, 0, 32'h00, 0);

        // Timeout: RAM never releases its stall.
        stall_n = 1000;
        expect_rsp(32'h0, 1, 1, TO + 2, 0, 0, 32'h4);
        do_req(0, SZ_WORD, 0, 32'h10, 0);
        stall_n = 2;
        expect_rsp(32'h80FF_7F01, 0, 1, 5, 0, 0, 32'h4);
        do_req(0, SZ_WORD, 0, 32'h10, 0);

        // Reset three cycles into a stalled write phase.
        stall_n = 30;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = SZ_WORD; cpu_sign = 1'b0;
        cpu_addr = 32'h30; cpu_wdata = 32'h55AA_55AA;
        repeat (4) @(posedge clk);
        #1;
        post("pre_rst_in_wr", {30'b0, ram_cs, ram_we}, 32'h3);
        rst_n = 1'b0;
        #1;
        post("rst_drops_ram", {30'b0, ram_cs, ram_we}, 32'h0);
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        post("post_rst_state", {29'b0, cpu_done, dbg_state}, {29'b0, 1'b0, ST_IDLE});
        post("mem_not_written", mem[12], 32'hCAFE_F00D);
        stall_n = 3;
        expect_rsp(32'hCAFE_F00D, 0, 1, 6, 0, 0, 32'hC);
        do_req(0, SZ_WORD, 0, 32'h30, 0);

        repeat (4) @(posedge clk);
        #1;
        post("exp_q_drained", 32'(exp_q.size()), 32'h0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller on the CPU side of the slow word-addressed data RAM. It accepts load/store requests from the MEM stage and drives the RAM's `cs`/`we`/`addr`/`din`, holding them stable until the RAM drops its stall. It then returns data or completion to the CPU and holds the pipeline stalled meanwhile. It also provides byte/halfword loads with sign/zero extension, sub-word stores via read-modify-write, misalignment detection and a stall timeout.

## Interface
- `TIMEOUT`, 64: max cycles per RAM phase before abort.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: request valid; held with all `cpu_*` fields stable until `cpu_done`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_size` in 2: 00 byte, 01 half, 10 word; 11 illegal.
- `cpu_sign` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-aligned.
- `cpu_rdata` out 32: load result, valid while `cpu_done`=1.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_err` out 1: qualifies `cpu_done`; misaligned/illegal size or timeout.
- `cpu_stall` out 1: `cpu_req & ~cpu_done`, combinational.
- `ram_cs` out 1: RAM chip select.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out 32: word address `{2'b00, cpu_addr[31:2]}`.
- `ram_din` out 32: full write word.
- `ram_dout` in 32: RAM read word.
- `ram_stall` in 1: RAM busy while `ram_cs`=1.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE, `cpu_req`=1:
  - misaligned (half with `addr[0]`, word with `addr[1:0]`≠0) or size 11 -> DONE with err; no RAM access.
  - load or sub-word store -> RD.
  - word store -> WR.
- RD: `ram_cs`=1, `ram_we`=0. Phase completes on the first rising edge with `ram_stall`=0; `ram_dout` is captured into a word register on that edge.
  - Load: extract the lane at `addr[1:0]` (byte) or `addr[1]` (half), extend per `cpu_sign`, go to DONE.
  - Sub-word store: merge `cpu_wdata` low byte/half into the captured word at that lane, load the result into `ram_din`, go to WR. `ram_cs` stays 1 and `ram_addr` is unchanged across the RD->WR transition.
- WR: `ram_cs`=1, `ram_we`=1. Completes on the first rising edge with `ram_stall`=0, then -> DONE.
- DONE: `cpu_done`=1 for exactly one cycle, `ram_cs`=0, -> IDLE. A new request is accepted no earlier than the cycle after DONE.
- Timeout: per-phase counter, width `$clog2(TIMEOUT+1)`, cleared on phase entry. When it reaches `TIMEOUT` with `ram_stall` still 1 -> DONE with err, and `cpu_rdata`=0.
- Store `cpu_rdata` = 0.
- `cpu_req` dropping outside IDLE is a protocol violation; the access completes regardless.

## Timing
- All `ram_*` and `cpu_rdata/done/err` are registered.
- `ram_addr`, `ram_we`, `ram_din` are constant for the entire phase. The RAM restarts its latency count on any address change, so glitch-free stability is mandatory.
- Latency with the RAM stall lasting N cycles after `cs` rises:
  - load / word store: `cpu_done` at N+2 cycles after the accept edge.
  - sub-word store: about 2N+3, less if the RAM acks the same-address write immediately.
- Misaligned: `cpu_done`+`cpu_err` on the 2nd cycle after accept.
- Reset (asynchronous, any state): state IDLE, all outputs 0, counters 0. Mid-access reset drops `ram_cs` immediately; no partial write beyond what the RAM has already committed.
- `ram_stall` is ignored while `ram_cs`=0.

## Structure
- Package `dmem_pkg`:
  - size encodings `SZ_BYTE/SZ_HALF/SZ_WORD`
  - state enum
  - function `align_ok(size, addr)`
- Sub-module `dmem_lane`, combinational:
  - load extract/extend (word, `addr[1:0]`, size, sign -> rdata)
  - store merge (old word, wdata, `addr[1:0]`, size -> new word)
- The FSM, timeout counter and registers live in `dmem_ctrl`.

## Test plan
- Word load: RAM model with 8-cycle stall, `addr`=0x10 holding 0xDEADBEEF -> `ram_addr`=0x4 stable throughout; `cpu_rdata`=0xDEADBEEF; one-cycle `cpu_done`; `cpu_stall` high until then.
- Byte loads: address 0x13, word 0x80FF7F01.
  - `cpu_sign`=1 -> 0xFFFFFF80.
  - address 0x12, `cpu_sign`=0 -> 0x000000FF.
- Half store: 0xABCD to 0x0A, word 0x11223344 -> one read phase, then write phase with `ram_din`=0xABCD3344; `ram_addr`=0x2 unchanged between phases; final RAM word 0xABCD3344.
- Misaligned: word load at 0x06 -> `cpu_done`+`cpu_err`, `ram_cs` never asserted.
- Timeout: `ram_stall` held 1, `TIMEOUT`=16 -> `cpu_err` pulse 16 cycles after phase entry; `ram_cs` drops; next request proceeds normally.
- Reset mid-write (`rst_n` low 3 cycles into WR) -> `ram_cs`/`ram_we` drop immediately; after release the FSM is in IDLE and a subsequent word load returns correct data.
